serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing D = A − B over WIDTH clock cycles, LSB first, with one full-subtractor cell and a registered borrow. It is the subtraction counterpart to the lab's combinational full-adder datapath. It trades area for latency in the sequential-arithmetic exercises, and a start/busy/done handshake lets a controller drive it.

---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B, LSB first, one full-subtractor cell.
// Define SERSUB_OVF_EN to add the registered signed-overflow output V.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SERSUB_OVF_EN
  output logic             V,
`endif
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sd_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             v_q;
`endif

  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] sd_d;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs; d_bit enters SD from the MSB side.
  assign a0       = sa_q[0];
  assign b0       = sb_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_d     = (~a0 & b0) | (~a0 & br_q) | (b0 & br_q);
  assign sd_d     = {d_bit, sd_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef SERSUB_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_q <= sa_q >> 1;
          sb_q <= sb_q >> 1;
          sd_q <= sd_d;
          br_q <= br_d;
          if (last_bit) begin
            // Counter is cleared rather than incremented so it never wraps.
            cnt_q   <= '0;
            d_q     <= sd_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SERSUB_OVF_EN
            v_q     <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign D           = d_q;
  assign Bout        = bout_q;
  assign dbg_state_o = state_q;
`ifdef SERSUB_OVF_EN
  assign V           = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 8): driver tasks push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 2;  // {v, bout, d}

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A     = '0;
  logic [WIDTH-1:0] B     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic [1:0]       dbg_state;
`ifdef SERSUB_OVF_EN
  logic             V;
`endif

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int busy_len  = 0;
  int last_done = -1;
  int prev_done = -1;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .D           (D),
    .Bout        (Bout),
`ifdef SERSUB_OVF_EN
    .V           (V),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           a;
    if (!rst_n) begin
      busy_len = 0;
    end else begin
      if (busy) busy_len++;
      if (done) begin
        prev_done = last_done;
        last_done = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done with D=%0h, expected no result", D);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result_D", 32'(D), 32'(e[WIDTH-1:0]));
          check("result_Bout", 32'(Bout), 32'(e[WIDTH]));
`ifdef SERSUB_OVF_EN
          check("result_V", 32'(V), 32'(e[WIDTH+1]));
`endif
          check("latency", 32'(cyc - a), 32'(WIDTH));
          check("busy_len", 32'(busy_len), 32'(WIDTH));
        end
        busy_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d_e, input logic bo_e, input logic v_e);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_wait: got busy=1 expected busy=0 within 40 cycles");
    end
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    exp_q.push_back({v_e, bo_e, d_e});
    acc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    A     = 8'($urandom_range(0, 255));
    B     = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    int acc1;
    int acc2;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef SERSUB_OVF_EN
    check("rst_V", 32'(V), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    issue(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    issue(8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b0);
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    issue(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    issue(8'h9C, 8'h00, 8'h9C, 1'b0, 1'b0);
    issue(8'h00, 8'h30, 8'hD0, 1'b1, 1'b0);
    wait_drain();

    // start during RUN must be ignored
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    A     = 8'hFF;
    B     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);

    // start held high: DONE accepts the next operation directly
    start = 1'b1;
    A     = 8'h20;
    B     = 8'h08;
    @(posedge clk);
    #1;
    acc1 = cyc;
    exp_q.push_back({1'b0, 1'b0, 8'h18});
    acc_q.push_back(acc1);
    guard = 0;
    @(negedge clk);
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    A = 8'h44;
    B = 8'h11;
    @(posedge clk);
    #1;
    acc2 = cyc;
    exp_q.push_back({1'b0, 1'b0, 8'h33});
    acc_q.push_back(acc2);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'(WIDTH + 1));
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    check("b2b_done_gap", 32'(last_done - prev_done), 32'(WIDTH + 1));

    // asynchronous reset in the middle of RUN
    issue(8'h77, 8'h11, 8'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_D", 32'(D), 32'd0);
    check("arst_Bout", 32'(Bout), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
`ifdef SERSUB_OVF_EN
    check("arst_V", 32'(V), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    wait_drain();
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
